// File: rtl/bp_pkg.sv
// bp_pkg: shared constants and the saturating-counter update for the gshare predictor
package bp_pkg;

    localparam int IDX_W_DEF = 10;
    localparam int GHR_W_DEF = 8;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        return taken ? ((ctr == CTR_ST) ? CTR_ST : ctr + 2'd1)
                     : ((ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1);
    endfunction

endpackage

// File: rtl/bp_pht.sv
// bp_pht: pattern history table of 2-bit saturating counters.
//   clk, rst      : clock, synchronous active-high reset (all entries -> weak-not-taken)
//   raddr, rdata  : combinational read port (decode-stage lookup)
//   we, waddr,
//   wtaken        : update port; the addressed counter moves toward wtaken
module bp_pht
    import bp_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] raddr,
    output logic [1:0]       rdata,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic             wtaken
);

    localparam int N = 1 << IDX_W;

    logic [N-1:0][1:0] mem_q, mem_d;

    // The read sees mem_q, so a same-cycle write is not bypassed to the reader.
    assign rdata = mem_q[raddr];

    always_comb begin
        mem_d = mem_q;
        if (we) mem_d[waddr] = ctr_next(mem_q[waddr], wtaken);
    end

    always_ff @(posedge clk) begin
        mem_q <= rst ? {N{CTR_WNT}} : mem_d;
    end

endmodule

// File: rtl/gshare_predictor.sv
// gshare_predictor: gshare conditional-branch predictor for the 5-stage MIPS pipeline.
//   clk, rst              : clock, synchronous active-high reset
//   pcF                   : fetch PC used to form the PHT index
//   instrD                : decode instruction, only the opcode is inspected
//   stallD, flushD        : hold / clear the F->D index register
//   flushE                : kills the branch entering E (no history shift, no update)
//   actual_takeE          : resolved direction of the branch in E
//   pred_takeD            : prediction for the branch in D
//   mispredictE           : valid E branch resolved opposite to its prediction
//   pred_takeE            : prediction carried with the branch in E
module gshare_predictor
    import bp_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF,
    parameter int GHR_W = GHR_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pcF,
    input  logic [31:0] instrD,
    input  logic        stallD,
    input  logic        flushD,
    input  logic        flushE,
    input  logic        actual_takeE,
    output logic        pred_takeD,
    output logic        mispredictE,
    output logic        pred_takeE
);

    logic [GHR_W-1:0] ghr_q, ghr_d, ghr_cke_q, ghr_cke_d;
    logic [IDX_W-1:0] idxd_q, idxd_d, idxe_q, idxe_d;
    logic             vale_q, vale_d, prede_q, prede_d;
    logic [IDX_W-1:0] idx_f;
    logic [1:0]       ctr_d;
    logic             isbr_d, shift_d;
    logic             unused_bits;

    assign unused_bits = &{1'b0, pcF, instrD[25:0], ghr_cke_q[GHR_W-1]};

    assign idx_f       = pcF[IDX_W+1:2] ^ IDX_W'(ghr_q);
    assign isbr_d      = instrD[31:26] inside {OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_REGIMM};
    assign pred_takeD  = isbr_d & ctr_d[1];
    assign shift_d     = isbr_d & ~stallD & ~flushE;
    assign mispredictE = vale_q & (prede_q ^ actual_takeE);
    assign pred_takeE  = prede_q;

    bp_pht #(.IDX_W(IDX_W)) u_pht (
        .clk    (clk),
        .rst    (rst),
        .raddr  (idxd_q),
        .rdata  (ctr_d),
        .we     (vale_q),
        .waddr  (idxe_q),
        .wtaken (actual_takeE)
    );

    // A mispredict repair rebuilds history from the branch's own checkpoint,
    // overriding any speculative shift from a younger branch in D.
    always_comb begin
        ghr_d     = mispredictE ? {ghr_cke_q[GHR_W-2:0], actual_takeE}
                  : shift_d     ? {ghr_q[GHR_W-2:0], pred_takeD} : ghr_q;
        idxd_d    = flushD ? '0 : stallD ? idxd_q : idx_f;
        vale_d    = shift_d;
        prede_d   = pred_takeD;
        idxe_d    = idxd_q;
        ghr_cke_d = ghr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_q     <= '0;
            idxd_q    <= '0;
            vale_q    <= 1'b0;
            prede_q   <= 1'b0;
            idxe_q    <= '0;
            ghr_cke_q <= '0;
        end else begin
            ghr_q     <= ghr_d;
            idxd_q    <= idxd_d;
            vale_q    <= vale_d;
            prede_q   <= prede_d;
            idxe_q    <= idxe_d;
            ghr_cke_q <= ghr_cke_d;
        end
    end

endmodule

// File: tb/tb_gshare_predictor.sv
// tb_gshare_predictor: directed table-driven and sequence checks of the gshare predictor
module tb_gshare_predictor;

    localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, BLEZ = 6'b000110;
    localparam logic [5:0] BGTZ = 6'b000111, REGIMM = 6'b000001, JMP = 6'b000010;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pcF = '0;
    logic [31:0] instrD = '0;
    logic        stallD = 1'b0, flushD = 1'b0, flushE = 1'b0, actual_takeE = 1'b0;
    logic        pred_takeD, mispredictE, pred_takeE;

    int n_chk = 0;
    int n_fail = 0;

    gshare_predictor dut (
        .clk          (clk),
        .rst          (rst),
        .pcF          (pcF),
        .instrD       (instrD),
        .stallD       (stallD),
        .flushD       (flushD),
        .flushE       (flushE),
        .actual_takeE (actual_takeE),
        .pred_takeD   (pred_takeD),
        .mispredictE  (mispredictE),
        .pred_takeE   (pred_takeE)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [5:0]  op;
        logic        t;
        logic        pred;
        logic        mis;
        logic [9:0]  idx;
        logic [1:0]  ctr;
        logic [7:0]  ghr;
    } vec_t;

    vec_t v[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        instrD = '0;
        pcF = '0;
        stallD = 1'b0;
        actual_takeE = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // One branch through F, D and E with idle slots around it.
    task automatic branch(input logic [31:0] pc, input logic [5:0] op, input logic t,
                          output logic p, output logic m);
        pcF = pc;
        instrD = '0;
        tick();
        instrD = {op, 26'h0};
        pcF = '0;
        #2 p = pred_takeD;
        tick();
        instrD = '0;
        actual_takeE = t;
        #2 m = mispredictE;
        tick();
        actual_takeE = 1'b0;
        #2;
    endtask

    initial begin
        logic p, m;
        int mis_cnt;
        v[0]  = '{32'h040, BEQ,    1'b1, 1'b0, 1'b1, 10'h010, 2'd2, 8'h01};
        v[1]  = '{32'h044, BNE,    1'b1, 1'b1, 1'b0, 10'h010, 2'd3, 8'h03};
        v[2]  = '{32'h04C, BLEZ,   1'b1, 1'b1, 1'b0, 10'h010, 2'd3, 8'h07};
        v[3]  = '{32'h05C, JMP,    1'b0, 1'b0, 1'b0, 10'h010, 2'd3, 8'h07};
        v[4]  = '{32'h05C, BGTZ,   1'b0, 1'b1, 1'b1, 10'h010, 2'd2, 8'h0E};
        v[5]  = '{32'h078, REGIMM, 1'b1, 1'b1, 1'b0, 10'h010, 2'd3, 8'h1D};
        v[6]  = '{32'h034, BEQ,    1'b0, 1'b1, 1'b1, 10'h010, 2'd2, 8'h3A};
        v[7]  = '{32'h0A8, BNE,    1'b0, 1'b1, 1'b1, 10'h010, 2'd1, 8'h74};
        v[8]  = '{32'h190, BEQ,    1'b0, 1'b0, 1'b0, 10'h010, 2'd0, 8'hE8};
        v[9]  = '{32'h3E0, BEQ,    1'b0, 1'b0, 1'b0, 10'h010, 2'd0, 8'hD0};
        v[10] = '{32'h800, BEQ,    1'b1, 1'b0, 1'b1, 10'h2D0, 2'd2, 8'hA1};

        // Reset state
        do_reset();
        instrD = {BEQ, 26'h0};
        #2;
        chk("rst_pred", {31'h0, pred_takeD}, 32'h0);
        chk("rst_mis", {31'h0, mispredictE}, 32'h0);
        chk("rst_ghr", {24'h0, dut.ghr_q}, 32'h0);
        chk("rst_pht0", {30'h0, dut.u_pht.mem_q[0]}, 32'h1);
        instrD = '0;
        tick();

        // Table: training one counter through its full range, plus a jump and a fresh entry
        for (int i = 0; i < 11; i++) begin
            branch(v[i].pc, v[i].op, v[i].t, p, m);
            chk($sformatf("v%0d_pred", i), {31'h0, p}, {31'h0, v[i].pred});
            chk($sformatf("v%0d_mis", i), {31'h0, m}, {31'h0, v[i].mis});
            chk($sformatf("v%0d_ctr", i), {30'h0, dut.u_pht.mem_q[v[i].idx]}, {30'h0, v[i].ctr});
            chk($sformatf("v%0d_ghr", i), {24'h0, dut.ghr_q}, {24'h0, v[i].ghr});
        end

        // Back-to-back branches, the older one mispredicts: younger speculative bit dropped
        do_reset();
        branch(32'h07C, BEQ, 1'b1, p, m);
        chk("b2b_train_ghr", {24'h0, dut.ghr_q}, 32'h01);
        pcF = 32'h040;
        tick();
        instrD = {BEQ, 26'h0};
        pcF = 32'h078;
        #2 chk("b2b_pred1", {31'h0, pred_takeD}, 32'h0);
        tick();
        instrD = {BNE, 26'h0};
        pcF = '0;
        actual_takeE = 1'b1;
        #2;
        chk("b2b_pred2", {31'h0, pred_takeD}, 32'h1);
        chk("b2b_mis1", {31'h0, mispredictE}, 32'h1);
        tick();
        instrD = '0;
        actual_takeE = 1'b1;
        #2;
        chk("b2b_ghr_repair", {24'h0, dut.ghr_q}, 32'h03);
        chk("b2b_mis2", {31'h0, mispredictE}, 32'h0);
        chk("b2b_predE2", {31'h0, pred_takeE}, 32'h1);
        tick();
        actual_takeE = 1'b0;
        #2;
        chk("b2b_ghr_after", {24'h0, dut.ghr_q}, 32'h03);
        chk("b2b_pht1", {30'h0, dut.u_pht.mem_q[10'h011]}, 32'h2);

        // Stall for three cycles with a predicted-taken branch in D
        do_reset();
        branch(32'h07C, BEQ, 1'b1, p, m);
        mis_cnt = 0;
        pcF = 32'h078;
        tick();
        instrD = {BEQ, 26'h0};
        stallD = 1'b1;
        #2 chk("stall_pred", {31'h0, pred_takeD}, 32'h1);
        for (int c = 0; c < 3; c++) begin
            if (mispredictE) mis_cnt++;
            tick();
            #2 chk($sformatf("stall_ghr%0d", c), {24'h0, dut.ghr_q}, 32'h01);
        end
        stallD = 1'b0;
        if (mispredictE) mis_cnt++;
        tick();
        instrD = '0;
        #2 chk("stall_ghr_shift", {24'h0, dut.ghr_q}, 32'h03);
        for (int c = 0; c < 3; c++) begin
            if (mispredictE) mis_cnt++;
            tick();
            #2;
        end
        chk("stall_mis_count", mis_cnt, 1);
        chk("stall_ghr_repair", {24'h0, dut.ghr_q}, 32'h02);

        // Same-index write in E and read in D: no bypass
        do_reset();
        pcF = 32'h040;
        tick();
        instrD = {BEQ, 26'h0};
        tick();
        actual_takeE = 1'b1;
        stallD = 1'b1;
        #2;
        chk("byp_old_pred", {31'h0, pred_takeD}, 32'h0);
        chk("byp_mis", {31'h0, mispredictE}, 32'h1);
        tick();
        actual_takeE = 1'b0;
        #2;
        chk("byp_new_pred", {31'h0, pred_takeD}, 32'h1);
        chk("byp_ctr", {30'h0, dut.u_pht.mem_q[10'h010]}, 32'h2);
        stallD = 1'b0;
        instrD = '0;
        tick();

        // Reset while a mispredicted branch sits in E
        do_reset();
        pcF = 32'h040;
        tick();
        instrD = {BEQ, 26'h0};
        tick();
        instrD = '0;
        actual_takeE = 1'b1;
        #2 chk("mid_rst_mis_before", {31'h0, mispredictE}, 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #2;
        chk("mid_rst_pht", {30'h0, dut.u_pht.mem_q[10'h010]}, 32'h1);
        chk("mid_rst_ghr", {24'h0, dut.ghr_q}, 32'h0);
        chk("mid_rst_mis", {31'h0, mispredictE}, 32'h0);
        actual_takeE = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
